// File: rtl/bufmem_arbiter.sv
// Round-robin arbiter for the shared single-port sector buffer RAM.
// Grants one of three requesters per ce-cycle, with bounded burst locking and registered RAM drive.
module bufmem_arbiter #(
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [2:0]        lock,
  input  logic [3*AW-1:0]   addr,
  input  logic [3*DW-1:0]   wdata,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DW-1:0]     rdata,
  output logic [1:0]        owner,
  output logic              busy,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_we,
  output logic [DW-1:0]     ram_di,
  input  logic [DW-1:0]     ram_do
);

  localparam logic [7:0] BurstMax = 8'(BURST_MAX);

  logic [2:0]    r_gnt;
  logic [2:0]    r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_owner;
  logic [7:0]    r_burst_cnt;
  logic [AW-1:0] r_ram_addr;
  logic          r_ram_we;
  logic [DW-1:0] r_ram_di;

  logic [1:0]    w_p1;
  logic [1:0]    w_p2;
  logic          w_hold;
  logic [1:0]    w_win;
  logic [7:0]    w_cnt_nxt;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_we;

  always_comb begin
    w_p1      = (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
    w_p2      = (w_p1 == 2'd2) ? 2'd0 : w_p1 + 2'd1;
    // burst_cnt==0 means no grant since reset, so a lock cannot claim priority yet
    w_hold    = (r_burst_cnt != 8'd0) && req[r_owner] && lock[r_owner] &&
                (r_burst_cnt < BurstMax);
    w_win     = r_owner;
    if (w_hold) begin
      w_win = r_owner;
    end else if (req[w_p1]) begin
      w_win = w_p1;
    end else if (req[w_p2]) begin
      w_win = w_p2;
    end
    w_cnt_nxt = w_hold ? r_burst_cnt + 8'd1 : 8'd1;
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (w_win == 2'(i)) begin
        w_addr  = addr[i*AW +: AW];
        w_wdata = wdata[i*DW +: DW];
        w_we    = we[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt       <= 3'b000;
      r_rvalid    <= 3'b000;
      r_rdata     <= '0;
      r_owner     <= 2'd2;
      r_burst_cnt <= 8'd0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_di    <= '0;
    end else if (ce) begin
      // a read granted last ce-cycle returns now; writes produce no return
      r_rvalid <= r_ram_we ? 3'b000 : r_gnt;
      if ((|r_gnt) && !r_ram_we) begin
        r_rdata <= ram_do;
      end
      if (|req) begin
        r_gnt       <= 3'b001 << w_win;
        r_owner     <= w_win;
        r_burst_cnt <= w_cnt_nxt;
        r_ram_addr  <= w_addr;
        r_ram_we    <= w_we;
        r_ram_di    <= w_wdata;
      end else begin
        r_gnt    <= 3'b000;
        r_ram_we <= 1'b0;
      end
    end
  end

  assign gnt      = r_gnt;
  assign rvalid   = r_rvalid;
  assign rdata    = r_rdata;
  assign owner    = r_owner;
  assign ram_addr = r_ram_addr;
  assign ram_we   = r_ram_we;
  assign ram_di   = r_ram_di;
  assign busy     = (|r_gnt) || (|r_rvalid) || r_ram_we;

endmodule

// File: tb/tb_bufmem_arbiter.sv
// Self-checking bench for bufmem_arbiter: directed test-plan steps then randomized traffic
// checked against a rule-level arbitration model and a shadow copy of the buffer RAM.
module tb_bufmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int BM = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce = 1'b0;
  logic [2:0]    req = 3'b000;
  logic [2:0]    we = 3'b000;
  logic [2:0]    lock = 3'b000;
  logic [AW-1:0] pa [3];
  logic [DW-1:0] pd [3];
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]    gnt;
  logic [2:0]    rvalid;
  logic [DW-1:0] rdata;
  logic [1:0]    owner;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  assign addr  = {pa[2], pa[1], pa[0]};
  assign wdata = {pd[2], pd[1], pd[0]};

  bufmem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .owner(owner), .busy(busy), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(int a);
    if (a == 341) return 8'hA5;
    return 8'(a * 7 + 3);
  endfunction

  // Buffer RAM: asynchronous read, write committed on a ce edge while ram_we is high
  logic          init_done = 1'b0;
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (ce && ram_we) begin
      mem[ram_addr] <= ram_di;
    end
  end
  assign ram_do = mem[ram_addr];

  // Reference model state
  int            checks = 0;
  int            failures = 0;
  int            m_owner;
  int            m_cnt;
  int            m_rd_port;
  logic [AW-1:0] m_rd_addr;
  logic [DW-1:0] model_mem [1024];
  logic [2:0]    e_gnt;
  logic [2:0]    e_rvalid;
  logic [DW-1:0] e_rdata;
  logic [AW-1:0] e_ram_addr;
  logic          e_ram_we;
  logic [DW-1:0] e_ram_di;

  task automatic model_reset();
    m_owner    = 2;
    m_cnt      = 0;
    m_rd_port  = -1;
    m_rd_addr  = '0;
    e_gnt      = 3'b000;
    e_rvalid   = 3'b000;
    e_rdata    = '0;
    e_ram_addr = '0;
    e_ram_we   = 1'b0;
    e_ram_di   = '0;
  endtask

  // One ce-qualified edge of the arbitration rules, applied to the inputs seen at that edge
  task automatic model_step();
    int  w;
    bit  found;
    if (m_rd_port >= 0) begin
      e_rvalid = 3'(1 << m_rd_port);
      e_rdata  = model_mem[m_rd_addr];
    end else begin
      e_rvalid = 3'b000;
    end
    m_rd_port = -1;
    if (req == 3'b000) begin
      e_gnt    = 3'b000;
      e_ram_we = 1'b0;
      return;
    end
    if (m_cnt > 0 && req[m_owner] && lock[m_owner] && m_cnt < BM) begin
      w = m_owner;
      m_cnt++;
    end else begin
      w = m_owner;
      found = 0;
      for (int i = 1; i <= 3; i++) begin
        if (!found && req[(m_owner + i) % 3]) begin
          w = (m_owner + i) % 3;
          found = 1;
        end
      end
      m_cnt = 1;
    end
    m_owner    = w;
    e_gnt      = 3'(1 << w);
    e_ram_addr = pa[w];
    e_ram_we   = we[w];
    e_ram_di   = pd[w];
    if (we[w]) model_mem[pa[w]] = pd[w];
    else begin
      m_rd_port = w;
      m_rd_addr = pa[w];
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(e_rvalid));
    chk({tag, ".rdata"}, 32'(rdata), 32'(e_rdata));
    chk({tag, ".owner"}, 32'(owner), 32'(m_owner));
    chk({tag, ".ram_addr"}, 32'(ram_addr), 32'(e_ram_addr));
    chk({tag, ".ram_we"}, 32'(ram_we), 32'(e_ram_we));
    chk({tag, ".ram_di"}, 32'(ram_di), 32'(e_ram_di));
    chk({tag, ".busy"}, 32'(busy), 32'((|e_gnt) || (|e_rvalid) || e_ram_we));
  endtask

  task automatic tick(logic ce_v, string tag);
    ce = ce_v;
    @(posedge clk);
    if (ce_v) model_step();
    #1;
    check_all(tag);
  endtask

  // Requesters drop a request once they see it granted
  task automatic retire();
    for (int p = 0; p < 3; p++) if (e_gnt[p]) req[p] = 1'b0;
  endtask

  task automatic new_txn(int p);
    req[p]  = 1'b1;
    we[p]   = 1'($urandom_range(0, 1));
    lock[p] = ($urandom_range(0, 2) == 0);
    pa[p]   = AW'($urandom_range(0, 31));
    pd[p]   = DW'($urandom_range(0, 255));
  endtask

  int exp_c [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    for (int p = 0; p < 3; p++) begin
      pa[p] = '0;
      pd[p] = '0;
    end
    for (int i = 0; i < 1024; i++) model_mem[i] = init_val(i);
    model_reset();
    repeat (2) @(posedge clk);
    init_done = 1'b1;
    #1;
    chk("rst.gnt", 32'(gnt), 0);
    chk("rst.rvalid", 32'(rvalid), 0);
    chk("rst.rdata", 32'(rdata), 0);
    chk("rst.owner", 32'(owner), 2);
    chk("rst.ram_addr", 32'(ram_addr), 0);
    chk("rst.ram_we", 32'(ram_we), 0);
    chk("rst.ram_di", 32'(ram_di), 0);
    chk("rst.busy", 32'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single read from port 2
    req = 3'b100; we = 3'b000; pa[2] = 10'h155;
    tick(1'b1, "a.grant");
    chk("a.gnt", 32'(gnt), 32'h4);
    chk("a.ram_addr", 32'(ram_addr), 32'h155);
    chk("a.ram_we", 32'(ram_we), 0);
    retire();
    tick(1'b1, "a.ret");
    chk("a.rvalid", 32'(rvalid), 32'h4);
    chk("a.rdata", 32'(rdata), 32'hA5);

    // Continuous requests from all ports, no lock
    req = 3'b111; pa[0] = 10'h010; pa[1] = 10'h021; pa[2] = 10'h032;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, "b.rr");
      chk("b.seq", 32'(gnt), 32'(1 << (i % 3)));
      chk("b.owner", 32'(owner), 32'(i % 3));
    end
    req = 3'b000;
    tick(1'b1, "b.drain");

    // Port 0 lock burst against port 1
    req = 3'b011; lock = 3'b001;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, "c.burst");
      chk("c.seq", 32'(gnt), 32'(1 << exp_c[i]));
    end
    req = 3'b000; lock = 3'b000;
    tick(1'b1, "c.drain");

    // Slow ce: write then readback from port 1
    req = 3'b010; we = 3'b010; pa[1] = 10'h3FF; pd[1] = 8'h3C;
    tick(1'b1, "d.wgrant");
    chk("d.gnt", 32'(gnt), 32'h2);
    chk("d.we0", 32'(ram_we), 1);
    retire();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, "d.hold");
      chk("d.gnt_hold", 32'(gnt), 32'h2);
      chk("d.we_hold", 32'(ram_we), 1);
    end
    we = 3'b000; req = 3'b010;
    tick(1'b1, "d.rgrant");
    chk("d.we_off", 32'(ram_we), 0);
    retire();
    tick(1'b0, "d.idle0");
    tick(1'b0, "d.idle1");
    tick(1'b1, "d.ret");
    chk("d.rvalid", 32'(rvalid), 32'h2);
    chk("d.rdata", 32'(rdata), 32'h3C);
    tick(1'b0, "d.rv_hold0");
    chk("d.rvalid_hold", 32'(rvalid), 32'h2);
    tick(1'b1, "d.drain");

    // Reset one clk after a port 1 read grant
    req = 3'b010; pa[1] = 10'h077;
    tick(1'b1, "e.grant");
    retire();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("e.gnt", 32'(gnt), 0);
    chk("e.owner", 32'(owner), 2);
    chk("e.busy", 32'(busy), 0);
    ce = 1'b1;
    @(posedge clk);
    #1;
    chk("e.rvalid", 32'(rvalid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    req = 3'b101; pa[0] = 10'h011; pa[2] = 10'h022;
    tick(1'b1, "e.first");
    chk("e.first_gnt", 32'(gnt), 32'h1);
    chk("e.no_rvalid", 32'(rvalid), 0);
    retire();
    tick(1'b1, "e.second");
    chk("e.second_gnt", 32'(gnt), 32'h4);
    retire();
    tick(1'b1, "e.drain");

    // Port 2 withdraws while port 0 holds the lock
    req = 3'b101; lock = 3'b001; pa[0] = 10'h044; pa[2] = 10'h2AA;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) req[2] = 1'b0;
      tick(1'b1, "f.lock");
      chk("f.gnt", 32'(gnt), 32'h1);
      chk("f.no_p2_addr", 32'(ram_addr != 10'h2AA), 1);
    end
    req = 3'b000; lock = 3'b000;
    tick(1'b1, "f.drain");

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      logic ce_v;
      ce_v = ($urandom_range(0, 3) != 0);
      tick(ce_v, "rnd");
      if (ce_v) begin
        for (int p = 0; p < 3; p++) begin
          if (e_gnt[p] || !req[p]) begin
            if ($urandom_range(0, 1) == 1) new_txn(p);
            else begin
              req[p]  = 1'b0;
              lock[p] = 1'b0;
            end
          end else if ($urandom_range(0, 15) == 0) begin
            req[p] = 1'b0;
          end
        end
      end
    end
    req = 3'b000;
    tick(1'b1, "end.drain0");
    tick(1'b1, "end.drain1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bufmem_arbiter.md
# bufmem_arbiter

Arbiter and sequencer for the floppy subsystem's 1 KB sector buffer RAM, which is single-ported and synchronous. It shares the buffer between three requesters: the WD1793 emulator's buffer port (port 0), the SPI DMA engine (port 1) and the 6502 workhorse CPU (port 2). It grants at most one access per clock-enabled cycle, uses round-robin priority with optional bounded burst locking, drives the RAM port from registers, and returns read data with a per-port valid pulse.

## Interface
- AW, 10, buffer address width
- DW, 8, data width
- BURST_MAX, 16, maximum consecutive locked grants to one port before forced rotation (2..255)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- ce  in  1  clock enable; all state advances only on clk edges with ce=1
- req  in  3  access request per port {cpu,dma,wd}; held until gnt
- we  in  3  1=write, 0=read, per port; held with req
- lock  in  3  burst lock per port; meaningful only while req is high
- addr  in  3*AW  packed addresses, port 0 in [AW-1:0]
- wdata  in  3*DW  packed write data, port 0 in [DW-1:0]
- gnt  out  3  one-hot grant pulse: access taken this cycle
- rvalid  out  3  one-hot read-data-valid pulse
- rdata  out  DW  read data, shared by all ports; qualified by rvalid
- owner  out  2  index of the last granted port
- busy  out  1  a RAM access or read return is in flight
- ram_addr  out  AW  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_di  out  DW  RAM write data (registered)
- ram_do  in  DW  RAM read data, valid one ce-cycle after the address cycle

## Operation
- Arbitration runs on every ce=1 edge where req≠0. A winner is chosen and gnt[w] is registered as a single-bit pulse. On the same edge, ram_addr, ram_we and ram_di are loaded from port w.
- Round-robin order after a grant to port k: k+1, k+2, k (mod 3).
- Lock/burst rule: if the previous winner k still has req[k]&lock[k]=1 and burst_cnt<BURST_MAX, k wins again and burst_cnt increments.
  - Otherwise normal rotation applies. burst_cnt resets to 1 on any grant to a different port, or on a grant without lock.
  - When burst_cnt reaches BURST_MAX, lock is ignored for the next arbitration. If another port is requesting it wins; if none is requesting, k is granted and burst_cnt restarts at 1.
- Requesters hold req/we/addr/wdata stable until they sample gnt. Deasserting req before gnt withdraws the request with no side effect.
- Reads: in the ce-cycle after the grant, rvalid[w]=1 and rdata=ram_do (registered). Writes produce no rvalid.
- ram_we is high for exactly the one ce-cycle following the grant edge of a write, and 0 otherwise.
- owner updates on each grant and holds otherwise.
- busy = any gnt or rvalid bit high, or ram_we high.
- Registered outputs change only on ce=1 edges and hold through ce=0 cycles. Consumers must qualify gnt and rvalid with ce.

## Timing
- Reset values: gnt=0, rvalid=0, rdata=0, ram_we=0, ram_addr=0, ram_di=0, owner=2 (so port 0 has top priority first), burst_cnt=0, busy=0.
- Latency:
  - req seen at edge E gives gnt high after E (zero wait if uncontended).
  - Read data: rvalid high after edge E+1, where edges are counted in ce-qualified cycles.
- Throughput: one access per ce-cycle. Back-to-back grants to different ports are allowed, and a read return overlaps the next access.
- Worst-case wait with no locks: 2 ce-cycles. With locks: 2·BURST_MAX ce-cycles.
- Simultaneous requests with no prior history: port 0 wins, then 1, then 2.
- Same port re-requesting immediately after gnt without lock loses to any other active requester.
- Address wrap: addresses are used as given (AW bits); no arithmetic is performed by this block.
- Reset mid-access: clears asynchronously. A pending rvalid is dropped and ram_we drops immediately. The first grant after reset follows the reset priority order.

## Test plan
- Single read, port 2 only: req=3'b100, we=0, addr=0x155, RAM preloaded with 0xA5 at 0x155 → gnt=3'b100 after edge 1; ram_addr=0x155, ram_we=0; rvalid=3'b100, rdata=0xA5 after edge 2.
- All three ports request continuously, no lock → grant sequence 0,1,2,0,1,2; owner follows; each rvalid arrives one ce-cycle after its gnt.
- Port 0 lock burst, BURST_MAX=4, port 1 also requesting → grants 0,0,0,0,1,0,… and burst_cnt resets on the grant to port 1.
- ce=1 every 3rd clk, port 1 write 0x3C to 0x3FF → ram_we high for exactly one ce-qualified period (3 clks); a readback returns 0x3C; gnt and rvalid hold across ce=0 clocks.
- reset_n pulsed low one clk after a port 1 read grant → rvalid never asserts; all outputs return to reset values immediately; the next simultaneous requests from ports 0 and 2 grant port 0 first.
- req[2] withdrawn before grant while port 0 is locked → no gnt[2]; no RAM access with port 2's address occurs.
